branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 135 +++++++++++++
 tb/tb_branch_predictor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor -- direct-mapped branch target buffer with 2-bit counters.
//
// Lookup is purely combinational on fetch_pc; updates from the MEM stage are
// written on the rising edge of the upd_en cycle. A same-cycle lookup to the
// entry being updated sees the old contents (no bypass).
//
// Optional feature: define BPRED_STATS_EN to build the resolved-branch and
// mispredict counters; without it both count ports are tied to 0.
//
// Ports
//   CLK, nRST          clock, asynchronous active-low reset
//   fetch_pc           PC in fetch
//   predict            predicted taken for fetch_pc
//   pred_target        predicted target (0 when predict=0)
//   pred_index         fetch_pc[INDEX_W+1:2], carried with the instruction
//   upd_en             resolved branch in MEM, pipeline not stalled
//   upd_pc/upd_index   PC and carried table index of the resolved branch
//   upd_taken          actual outcome
//   upd_predict        prediction carried with the branch
//   upd_target         computed branch target
//   mispredict         upd_en & (upd_predict != upd_taken)
//   branch_count       resolved-branch counter (stats build only)
//   miss_count         mispredict counter (stats build only)
module branch_predictor #(
  parameter int INDEX_W = 3
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [31:0]        fetch_pc,
  output logic               predict,
  output logic [31:0]        pred_target,
  output logic [INDEX_W-1:0] pred_index,
  input  logic               upd_en,
  input  logic [31:0]        upd_pc,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic               upd_taken,
  input  logic               upd_predict,
  input  logic [31:0]        upd_target,
  output logic               mispredict,
  output logic [31:0]        branch_count,
  output logic [31:0]        miss_count
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = 30 - INDEX_W;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] STK = 2'b11;

  logic             r_valid [ENTRIES];
  logic [TAG_W-1:0] r_tag   [ENTRIES];
  logic [31:0]      r_tgt   [ENTRIES];
  logic [1:0]       r_cnt   [ENTRIES];

  logic [INDEX_W-1:0] w_fidx;
  logic [TAG_W-1:0]   w_ftag;
  logic [TAG_W-1:0]   w_utag;
  logic               w_uhit;
  logic [1:0]         w_cnt_nxt;
  logic               w_unused;

  // ---------------- lookup ----------------
  assign w_fidx      = fetch_pc[INDEX_W+1:2];
  assign w_ftag      = fetch_pc[31:INDEX_W+2];
  assign predict     = r_valid[w_fidx] & (r_tag[w_fidx] == w_ftag) & r_cnt[w_fidx][1];
  assign pred_target = predict ? r_tgt[w_fidx] : 32'h0;
  assign pred_index  = w_fidx;

  // ---------------- update ----------------
  // Write address is the index carried down the pipe, not re-derived from upd_pc.
  assign w_utag     = upd_pc[31:INDEX_W+2];
  assign w_uhit     = r_valid[upd_index] & (r_tag[upd_index] == w_utag);
  assign mispredict = upd_en & (upd_predict != upd_taken);

  always_comb begin
    w_cnt_nxt = r_cnt[upd_index];
    if (upd_taken) begin
      if (r_cnt[upd_index] != STK) w_cnt_nxt = r_cnt[upd_index] + 2'd1;
    end else begin
      if (r_cnt[upd_index] != SNT) w_cnt_nxt = r_cnt[upd_index] - 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_tgt[i]   <= '0;
        r_cnt[i]   <= WNT;
      end
    end else if (upd_en) begin
      if (w_uhit) begin
        r_cnt[upd_index] <= w_cnt_nxt;
        if (upd_taken) r_tgt[upd_index] <= upd_target;
      end else if (upd_taken) begin
        // Allocate only on a taken miss; a not-taken miss leaves the entry alone.
        r_valid[upd_index] <= 1'b1;
        r_tag[upd_index]   <= w_utag;
        r_tgt[upd_index]   <= upd_target;
        r_cnt[upd_index]   <= WT;
      end
    end
  end

  // ---------------- statistics ----------------
`ifdef BPRED_STATS_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_branch_count <= '0;
      r_miss_count   <= '0;
    end else begin
      if (upd_en && (r_branch_count != 32'hFFFF_FFFF))
        r_branch_count <= r_branch_count + 32'd1;
      if (mispredict && (r_miss_count != 32'hFFFF_FFFF))
        r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign branch_count = r_branch_count;
  assign miss_count   = r_miss_count;
`else
  assign branch_count = 32'h0;
  assign miss_count   = 32'h0;
`endif

  // Low PC bits are word-offset / index bits that the table never stores.
  assign w_unused = ^{fetch_pc[1:0], upd_pc[INDEX_W+1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor -- directed scoreboard bench for branch_predictor.
// Each step drives fetch/update inputs after the falling edge, pushes the
// expected combinational outputs, then pops and checks them 1 ns later.
module tb_branch_predictor;

  localparam int IW = 3;

`ifdef BPRED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          nRST;
  logic [31:0]   fetch_pc;
  logic          predict;
  logic [31:0]   pred_target;
  logic [IW-1:0] pred_index;
  logic          upd_en;
  logic [31:0]   upd_pc;
  logic [IW-1:0] upd_index;
  logic          upd_taken;
  logic          upd_predict;
  logic [31:0]   upd_target;
  logic          mispredict;
  logic [31:0]   branch_count;
  logic [31:0]   miss_count;

  branch_predictor #(.INDEX_W(IW)) dut (
    .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc), .predict(predict),
    .pred_target(pred_target), .pred_index(pred_index), .upd_en(upd_en),
    .upd_pc(upd_pc), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_predict(upd_predict), .upd_target(upd_target), .mispredict(mispredict),
    .branch_count(branch_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          predict;
    logic [31:0]   target;
    logic [IW-1:0] index;
    logic          mispredict;
    logic [31:0]   bcnt;
    logic [31:0]   mcnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_bcnt = 0;   // model of branch_count
  int   m_mcnt = 0;   // model of miss_count

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, ".predict"},    {31'd0, predict},    {31'd0, e.predict});
    check({tag, ".target"},     pred_target,         e.target);
    check({tag, ".index"},      {29'd0, pred_index}, {29'd0, e.index});
    check({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, e.mispredict});
    check({tag, ".bcnt"},       branch_count,        e.bcnt);
    check({tag, ".mcnt"},       miss_count,          e.mcnt);
  endtask

  // One cycle: drive, push expectation, check before the rising edge,
  // then advance the count model for the edge that follows.
  task automatic step(input string tag, input logic [31:0] fpc,
                      input logic en, input logic [31:0] pc, input logic taken,
                      input logic pred, input logic [31:0] tgt,
                      input logic exp_pred, input logic [31:0] exp_tgt);
    exp_t e;
    logic miss;
    @(negedge CLK);
    fetch_pc    = fpc;
    upd_en      = en;
    upd_pc      = pc;
    upd_index   = pc[IW+1:2];
    upd_taken   = taken;
    upd_predict = pred;
    upd_target  = tgt;
    miss        = en & (pred != taken);
    e.predict    = exp_pred;
    e.target     = exp_tgt;
    e.index      = fpc[IW+1:2];
    e.mispredict = miss;
    e.bcnt       = STATS ? 32'(m_bcnt) : 32'h0;
    e.mcnt       = STATS ? 32'(m_mcnt) : 32'h0;
    sb.push_back(e);
    #1;
    pop_check(tag);
    if (en)   m_bcnt++;
    if (miss) m_mcnt++;
  endtask

  initial begin
    exp_t e;
    nRST = 1'b0; fetch_pc = 32'h40; upd_en = 1'b0; upd_pc = '0; upd_index = '0;
    upd_taken = 1'b0; upd_predict = 1'b0; upd_target = '0;

    // Reset state
    e = '{predict: 1'b0, target: 32'h0, index: '0, mispredict: 1'b0, bcnt: 32'h0, mcnt: 32'h0};
    sb.push_back(e);
    #2;
    pop_check("reset");
    @(negedge CLK); nRST = 1'b1;

    //   tag          fetch  en  pc     tk  prd tgt       exp_p exp_tgt
    // Taken miss allocates; same-cycle lookup sees old (empty) entry.
    step("alloc",     32'h40, 1, 32'h40, 1, 0, 32'h100, 0, 32'h0);
    step("hit_wt",    32'h40, 0, 32'h0,  0, 0, 32'h0,   1, 32'h100);
    step("nt1",       32'h40, 1, 32'h40, 0, 1, 32'h0,   1, 32'h100);  // WT->WNT
    step("nt2",       32'h40, 1, 32'h40, 0, 0, 32'h0,   0, 32'h0);    // WNT->SNT
    step("nt3",       32'h40, 1, 32'h40, 0, 0, 32'h0,   0, 32'h0);    // stays SNT
    step("tk1",       32'h40, 1, 32'h40, 1, 0, 32'h100, 0, 32'h0);    // SNT->WNT
    step("tk2",       32'h40, 1, 32'h40, 1, 0, 32'h100, 0, 32'h0);    // WNT->WT
    step("after_tk2", 32'h40, 0, 32'h0,  0, 0, 32'h0,   1, 32'h100);
    // Aliasing PC at the same index with another tag.
    step("alias",     32'h60, 1, 32'h60, 0, 0, 32'h0,   0, 32'h0);
    step("orig_kept", 32'h40, 0, 32'h60, 1, 1, 32'hDEAD, 1, 32'h100);
    // upd_en low with live-looking inputs changes nothing.
    step("en_low",    32'h44, 0, 32'h44, 1, 0, 32'h200, 0, 32'h0);
    step("en_low_ck", 32'h44, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0);
    // Second index; taken overwrites target on a hit.
    step("alloc_i1",  32'h44, 1, 32'h44, 1, 0, 32'h300, 0, 32'h0);
    step("tgt_upd",   32'h44, 1, 32'h44, 1, 1, 32'h380, 1, 32'h300);
    step("tgt_new",   32'h44, 0, 32'h0,  0, 0, 32'h0,   1, 32'h380);

    // Reset asserted while an update is pending: the update is discarded.
    step("pre_rst",   32'h40, 1, 32'h48, 1, 0, 32'h500, 1, 32'h100);
    // step() left the update inputs live; pull reset before the rising edge.
    #1 nRST = 1'b0;
    #1;
    m_bcnt = 0; m_mcnt = 0;
    check("rst_async.predict", {31'd0, predict}, 32'h0);
    check("rst_async.target",  pred_target, 32'h0);
    check("rst_async.bcnt",    branch_count, 32'h0);
    check("rst_async.mcnt",    miss_count, 32'h0);
    @(negedge CLK); nRST = 1'b1; upd_en = 1'b0;
    step("rst_drop",  32'h48, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0);
    step("rst_clr",   32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0);
    step("post_cnt",  32'h40, 1, 32'h40, 1, 0, 32'h100, 0, 32'h0);
    step("post_hit",  32'h40, 0, 32'h0,  0, 0, 32'h0,   1, 32'h100);

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
